// File: rtl/fpnew_sched_pkg.sv
// Shared types for the FPU request scheduler: the request/response payloads and the scheduler state enum.
// The payload layout follows fpnew_pkg field types at an operand width of FpWidth.
package fpnew_sched_pkg;

    localparam int unsigned FpWidth     = 64;
    localparam int unsigned NumOperands = 3;

    typedef enum logic [2:0] {
        RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [NumOperands-1:0][FpWidth-1:0] operands;
        roundmode_e                          rnd_mode;
        operation_e                          op;
        logic                                op_mod;
        fp_format_e                          src_fmt;
        fp_format_e                          dst_fmt;
        int_format_e                         int_fmt;
        logic                                vectorial_op;
    } req_payload_t;

    typedef struct packed {
        logic [FpWidth-1:0] result;
        status_t            status;
    } rsp_payload_t;

    typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_DRAIN} sched_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpnew_sched_rr_pick.sv
// Combinational rotate-priority picker: first eligible requester at or after the pointer, wrapping at NumReq.
module fpnew_sched_rr_pick #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned IdWidth = 2
) (
    input  logic [NumReq-1:0]  i_eligible,
    input  logic [IdWidth-1:0] i_rr_ptr,
    output logic [NumReq-1:0]  o_grant,
    output logic [IdWidth-1:0] o_idx,
    output logic               o_valid
);

    logic [IdWidth:0]   w_sum;
    logic [IdWidth-1:0] w_k;
    logic               w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int off = 0; off < int'(NumReq); off++) begin
            w_sum = {1'b0, i_rr_ptr} + (IdWidth+1)'(off);
            if (w_sum >= (IdWidth+1)'(NumReq)) begin
                w_sum = w_sum - (IdWidth+1)'(NumReq);
            end
            w_k = w_sum[IdWidth-1:0];
            if (!w_found && i_eligible[w_k]) begin
                w_found      = 1'b1;
                o_idx        = w_k;
                o_grant[w_k] = 1'b1;
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/fpnew_req_scheduler.sv
// Shares one FPU among NumReq requesters: round-robin issue, tag-routed responses, flush and drain.
// Defining FPNEW_REQ_SCHED_PERF_EN adds per-requester issued_o / stall_o counters.
module fpnew_req_scheduler
    import fpnew_sched_pkg::*;
#(
    parameter  int unsigned NumReq         = 4,
    parameter  int unsigned MaxOutstanding = 4,
    parameter  int unsigned Width          = FpWidth,
    localparam int unsigned IdWidth        = id_width(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  req_payload_t [NumReq-1:0]    req_i,
    output logic                         fpu_in_valid_o,
    input  logic                         fpu_in_ready_i,
    output req_payload_t                 fpu_req_o,
    output logic [IdWidth-1:0]           fpu_tag_o,
    input  logic                         fpu_out_valid_i,
    output logic                         fpu_out_ready_o,
    input  rsp_payload_t                 fpu_rsp_i,
    input  logic [IdWidth-1:0]           fpu_tag_i,
    output logic                         fpu_flush_o,
    input  logic                         fpu_busy_i,
    output logic [NumReq-1:0]            rsp_valid_o,
    input  logic [NumReq-1:0]            rsp_ready_i,
    output rsp_payload_t                 rsp_o,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic                         err_o
`ifdef FPNEW_REQ_SCHED_PERF_EN
    ,
    output logic [NumReq-1:0][31:0]      issued_o,
    output logic [NumReq-1:0][31:0]      stall_o
`endif
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if (Width != FpWidth) begin : g_width_check
        $error("Width must equal fpnew_sched_pkg::FpWidth");
    end

    sched_state_e              r_state, w_state_nxt;
    logic [IdWidth-1:0]        r_rr_ptr;
    logic [IdWidth-1:0]        r_hold_idx;
    logic [NumReq-1:0][CntW-1:0] r_cnt;
    logic                      r_err;

    logic [NumReq-1:0]  w_eligible;
    logic [NumReq-1:0]  w_pick_grant;
    logic [IdWidth-1:0] w_pick_idx;
    logic               w_pick_any;
    logic               w_hold;
    logic               w_drain;
    logic [IdWidth-1:0] w_gnt_idx;
    logic [NumReq-1:0]  w_gnt_onehot;
    logic               w_in_valid;
    logic               w_issue;
    logic               w_tag_ok;
    logic               w_rsp_fire;
    logic               w_err_set;
    logic [NumReq-1:0]  w_inc;
    logic [NumReq-1:0]  w_dec;

    always_comb begin
        for (int k = 0; k < int'(NumReq); k++) begin
            w_eligible[k] = req_valid_i[k] & (r_cnt[k] < CntW'(MaxOutstanding));
        end
    end

    fpnew_sched_rr_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_pick_grant),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_any)
    );

    // A flush cycle behaves like DRAIN so the pending grant is dropped.
    assign w_drain      = (r_state == ST_DRAIN) | flush_i;
    assign w_hold       = (r_state == ST_HOLD);
    assign w_gnt_idx    = w_hold ? r_hold_idx : w_pick_idx;
    assign w_gnt_onehot = w_hold ? (NumReq'(1) << r_hold_idx) : w_pick_grant;
    assign w_in_valid   = ~rst_i & ~w_drain & (w_hold ? req_valid_i[r_hold_idx] : w_pick_any);
    assign w_issue      = w_in_valid & fpu_in_ready_i;

    assign fpu_in_valid_o = w_in_valid;
    assign fpu_req_o      = req_i[w_gnt_idx];
    assign fpu_tag_o      = w_gnt_idx;
    assign req_ready_o    = w_issue ? w_gnt_onehot : '0;
    assign fpu_flush_o    = flush_i & ~rst_i;

    assign w_tag_ok   = 32'(fpu_tag_i) < NumReq;
    assign w_rsp_fire = ~rst_i & ~w_drain & fpu_out_valid_i & w_tag_ok & rsp_ready_i[fpu_tag_i];
    assign w_err_set  = ~rst_i & fpu_out_valid_i &
                        (~w_tag_ok | (w_rsp_fire & (r_cnt[fpu_tag_i] == '0)));

    always_comb begin
        rsp_valid_o     = '0;
        fpu_out_ready_o = 1'b0;
        if (!rst_i) begin
            if (w_drain || !w_tag_ok) begin
                fpu_out_ready_o = 1'b1;
            end else begin
                fpu_out_ready_o          = rsp_ready_i[fpu_tag_i];
                rsp_valid_o[fpu_tag_i]   = fpu_out_valid_i;
            end
        end
    end

    assign rsp_o  = fpu_rsp_i;
    assign err_o  = r_err;
    assign busy_o = (r_state != ST_ARB) | (|r_cnt);

    always_comb begin
        for (int k = 0; k < int'(NumReq); k++) begin
            w_inc[k] = w_issue & (w_gnt_idx == IdWidth'(k));
            w_dec[k] = w_rsp_fire & (fpu_tag_i == IdWidth'(k)) & (r_cnt[k] != '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_DRAIN;
        end else begin
            unique case (r_state)
                ST_ARB:   if (w_in_valid && !fpu_in_ready_i) w_state_nxt = ST_HOLD;
                ST_HOLD:  if (w_issue || !req_valid_i[r_hold_idx]) w_state_nxt = ST_ARB;
                ST_DRAIN: if (!fpu_busy_i) w_state_nxt = ST_ARB;
                default:  w_state_nxt = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_hold_idx <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARB) begin
                r_hold_idx <= w_pick_idx;
            end
            if (w_issue) begin
                r_rr_ptr <= (w_gnt_idx == IdWidth'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            for (int k = 0; k < int'(NumReq); k++) begin
                if (flush_i) begin
                    r_cnt[k] <= '0;
                end else if (w_inc[k] && !w_dec[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (w_dec[k] && !w_inc[k]) begin
                    r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end
        end
    end

`ifdef FPNEW_REQ_SCHED_PERF_EN
    logic [NumReq-1:0][31:0] r_issued;
    logic [NumReq-1:0][31:0] r_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            for (int k = 0; k < int'(NumReq); k++) begin
                if (req_ready_o[k]) begin
                    r_issued[k] <= r_issued[k] + 32'd1;
                end
                if (req_valid_i[k] && !req_ready_o[k]) begin
                    r_stall[k] <= r_stall[k] + 32'd1;
                end
            end
        end
    end

    assign issued_o = r_issued;
    assign stall_o  = r_stall;
`endif

endmodule

// File: tb/tb_fpnew_req_scheduler.sv
// Directed bench for fpnew_req_scheduler: main instance NumReq=4/MaxOutstanding=2,
// plus a NumReq=5 instance so an out-of-range response tag can be presented.
module tb_fpnew_req_scheduler;
    import fpnew_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]          req_valid, req_ready, rsp_valid, rsp_ready;
    req_payload_t [3:0]  req;
    logic                fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready;
    logic                fpu_flush, fpu_busy, flush, busy, err;
    req_payload_t        fpu_req;
    logic [1:0]          fpu_tag, fpu_tag_in;
    rsp_payload_t        fpu_rsp, rsp;

    logic [4:0]          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    req_payload_t [4:0]  b_req;
    logic                b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic                b_fpu_flush, b_fpu_busy, b_flush, b_busy, b_err;
    req_payload_t        b_fpu_req;
    logic [2:0]          b_tag, b_tag_in;
    rsp_payload_t        b_fpu_rsp, b_rsp;

`ifdef FPNEW_REQ_SCHED_PERF_EN
    logic [3:0][31:0] issued, stall;
    logic [4:0][31:0] b_issued, b_stall;
`endif

    fpnew_req_scheduler #(.NumReq(4), .MaxOutstanding(2), .Width(64)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_req_o(fpu_req), .fpu_tag_o(fpu_tag),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_rsp_i(fpu_rsp), .fpu_tag_i(fpu_tag_in),
        .fpu_flush_o(fpu_flush), .fpu_busy_i(fpu_busy),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp),
        .flush_i(flush), .busy_o(busy), .err_o(err)
`ifdef FPNEW_REQ_SCHED_PERF_EN
        , .issued_o(issued), .stall_o(stall)
`endif
    );

    fpnew_req_scheduler #(.NumReq(5), .MaxOutstanding(2), .Width(64)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_i(b_req),
        .fpu_in_valid_o(b_in_valid), .fpu_in_ready_i(b_in_ready),
        .fpu_req_o(b_fpu_req), .fpu_tag_o(b_tag),
        .fpu_out_valid_i(b_out_valid), .fpu_out_ready_o(b_out_ready),
        .fpu_rsp_i(b_fpu_rsp), .fpu_tag_i(b_tag_in),
        .fpu_flush_o(b_fpu_flush), .fpu_busy_i(b_fpu_busy),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_o(b_rsp),
        .flush_i(b_flush), .busy_o(b_busy), .err_o(b_err)
`ifdef FPNEW_REQ_SCHED_PERF_EN
        , .issued_o(b_issued), .stall_o(b_stall)
`endif
    );

    task automatic set_idle();
        req_valid = '0; fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_tag_in = '0;
        rsp_ready = '0; flush = 1'b0; fpu_busy = 1'b0;
        b_req_valid = '0; b_in_ready = 1'b0; b_out_valid = 1'b0; b_tag_in = '0;
        b_rsp_ready = '1; b_flush = 1'b0; b_fpu_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF; fpu_in_ready = 1'b1; fpu_out_valid = 1'b1; fpu_tag_in = 2'd2;
        rsp_ready = 4'hF; flush = 1'b1; b_out_valid = 1'b1; b_tag_in = 3'd5;
        #1;
        n_cmp++; if (fpu_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got %b want 0", fpu_in_valid); end
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        n_cmp++; if (fpu_out_ready !== 1'b0) begin n_err++; $display("FAIL reset_out_ready: got %b want 0", fpu_out_ready); end
        n_cmp++; if (fpu_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", fpu_flush); end
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (b_err !== 1'b0) begin n_err++; $display("FAIL reset_b_err: got %b want 0", b_err); end
    endtask

    task automatic test_round_robin();
        int         exp_g [5] = '{0, 1, 2, 3, 0};
        logic [1:0] prev   = '0;
        logic       prev_v = 1'b0;
        logic [3:0] exp_mask;
        logic [3:0] exp_rsp;
        logic [63:0] exp_op;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'hF; fpu_in_ready = 1'b1; rsp_ready = 4'hF;
            fpu_out_valid = prev_v; fpu_tag_in = prev;
            #1;
            exp_mask = 4'b0001 << exp_g[i];
            exp_rsp  = prev_v ? (4'b0001 << prev) : 4'b0000;
            exp_op   = 64'hA0 + 64'(exp_g[i]);
            n_cmp++; if (fpu_tag !== 2'(exp_g[i])) begin n_err++; $display("FAIL rr_tag[%0d]: got %0d want %0d", i, fpu_tag, exp_g[i]); end
            n_cmp++; if (req_ready !== exp_mask) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_mask); end
            n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", i, rsp_valid, exp_rsp); end
            n_cmp++; if (fpu_req.operands[0] !== exp_op) begin n_err++; $display("FAIL rr_payload[%0d]: got %h want %h", i, fpu_req.operands[0], exp_op); end
            prev = 2'(exp_g[i]); prev_v = 1'b1;
        end
        @(negedge clk);
        req_valid = '0; fpu_out_valid = 1'b1; fpu_tag_in = prev;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL rr_last_rsp: got %b want 0001", rsp_valid); end
        n_cmp++; if (rsp !== fpu_rsp) begin n_err++; $display("FAIL rr_rsp_data: got %h want %h", rsp, fpu_rsp); end
        @(negedge clk);
        set_idle();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_hold();
        logic [3:0] vals  [5] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        logic       rdys  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] tags  [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        logic [3:0] readys[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = vals[i]; fpu_in_ready = rdys[i];
            #1;
            n_cmp++; if (fpu_tag !== tags[i] || fpu_in_valid !== 1'b1) begin n_err++; $display("FAIL hold_tag[%0d]: got %0d/%b want %0d/1", i, fpu_tag, fpu_in_valid, tags[i]); end
            n_cmp++; if (req_ready !== readys[i]) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want %b", i, req_ready, readys[i]); end
        end
    endtask

    task automatic test_max_outstanding();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid = 4'b0010; fpu_in_ready = 1'b1;
            #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL max_issue[%0d]: got %b want 0010", i, req_ready); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000 || fpu_in_valid !== 1'b0) begin n_err++; $display("FAIL max_block: got %b/%b want 0000/0", req_ready, fpu_in_valid); end
        @(negedge clk);
        fpu_out_valid = 1'b1; fpu_tag_in = 2'd1; rsp_ready = 4'b0010;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0010 || fpu_out_ready !== 1'b1) begin n_err++; $display("FAIL max_rsp: got %b/%b want 0010/1", rsp_valid, fpu_out_ready); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL max_block_rsp_cycle: got %b want 0000", req_ready); end
        @(negedge clk);
        fpu_out_valid = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL max_third_issue: got %b want 0010", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL max_busy: got %b want 1", busy); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000; fpu_in_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL same_first: got %b want 1000", req_ready); end
        @(negedge clk);
        fpu_out_valid = 1'b1; fpu_tag_in = 2'd3; rsp_ready = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000 || rsp_valid !== 4'b1000) begin n_err++; $display("FAIL same_both: got %b/%b want 1000/1000", req_ready, rsp_valid); end
        @(negedge clk);
        fpu_out_valid = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL same_cnt_one: got %b want 1000", req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL same_cnt_two: got %b want 0000", req_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid = '0; fpu_out_valid = 1'b1; fpu_tag_in = 2'd3;
        end
        @(negedge clk);
        fpu_out_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL same_drained: got busy %b err %b want 0 0", busy, err); end
        @(negedge clk);
        fpu_out_valid = 1'b1; fpu_tag_in = 2'd1; rsp_ready = 4'b0010;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL zero_cnt_delivered: got %b want 0010", rsp_valid); end
        @(negedge clk);
        fpu_out_valid = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_cnt_err: got err %b busy %b want 1 0", err, busy); end
    endtask

    task automatic test_bad_tag();
        do_reset();
        @(negedge clk);
        b_out_valid = 1'b1; b_tag_in = 3'd5;
        #1;
        n_cmp++; if (b_rsp_valid !== 5'b00000) begin n_err++; $display("FAIL badtag_rsp_valid: got %b want 00000", b_rsp_valid); end
        n_cmp++; if (b_out_ready !== 1'b1) begin n_err++; $display("FAIL badtag_out_ready: got %b want 1", b_out_ready); end
        @(negedge clk);
        b_out_valid = 1'b0;
        #1;
        n_cmp++; if (b_err !== 1'b1) begin n_err++; $display("FAIL badtag_err: got %b want 1", b_err); end
        @(negedge clk);
        #1;
        n_cmp++; if (b_err !== 1'b1) begin n_err++; $display("FAIL badtag_sticky: got %b want 1", b_err); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 4'b0111; fpu_in_ready = 1'b1;
            #1;
            n_cmp++; if (fpu_tag !== 2'(i)) begin n_err++; $display("FAIL flush_fill[%0d]: got %0d want %0d", i, fpu_tag, i); end
        end
        @(negedge clk);
        flush = 1'b1; fpu_busy = 1'b1;
        #1;
        n_cmp++; if (fpu_flush !== 1'b1) begin n_err++; $display("FAIL flush_pulse: got %b want 1", fpu_flush); end
        n_cmp++; if (fpu_in_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL flush_abort: got %b/%b want 0/0000", fpu_in_valid, req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            flush = 1'b0; fpu_busy = (i < 3);
            fpu_out_valid = (i == 1); fpu_tag_in = 2'd1; rsp_ready = 4'b0000;
            #1;
            n_cmp++; if (fpu_flush !== 1'b0 || fpu_in_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL drain[%0d]: got flush %b in_valid %b busy %b want 0 0 1", i, fpu_flush, fpu_in_valid, busy); end
            if (i == 1) begin
                n_cmp++; if (rsp_valid !== 4'b0000 || fpu_out_ready !== 1'b1) begin n_err++; $display("FAIL drain_swallow: got %b/%b want 0000/1", rsp_valid, fpu_out_ready); end
            end
        end
        @(negedge clk);
        fpu_out_valid = 1'b0; req_valid = 4'b1111; fpu_in_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_exit_busy: got %b want 0", busy); end
        n_cmp++; if (fpu_tag !== 2'd3 || fpu_in_valid !== 1'b1) begin n_err++; $display("FAIL flush_rr_kept: got %0d/%b want 3/1", fpu_tag, fpu_in_valid); end
    endtask

`ifdef FPNEW_REQ_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'b0001; fpu_in_ready = 1'b0;
        end
        @(negedge clk);
        fpu_in_ready = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        n_cmp++; if (stall[0] !== 32'd5) begin n_err++; $display("FAIL perf_stall0: got %0d want 5", stall[0]); end
        n_cmp++; if (issued[0] !== 32'd1) begin n_err++; $display("FAIL perf_issued0: got %0d want 1", issued[0]); end
        n_cmp++; if (stall[1] !== 32'd0) begin n_err++; $display("FAIL perf_stall1: got %0d want 0", stall[1]); end
    endtask
`endif

    initial begin
        set_idle();
        for (int k = 0; k < 4; k++) begin
            req[k] = '0;
            req[k].operands[0] = 64'hA0 + 64'(k);
        end
        for (int k = 0; k < 5; k++) begin
            b_req[k] = '0;
        end
        fpu_rsp.result   = 64'hDEAD_BEEF_0000_0001;
        fpu_rsp.status   = 5'b00101;
        b_fpu_rsp        = '0;
        test_reset();
        test_round_robin();
        test_hold();
        test_max_outstanding();
        test_same_cycle();
        test_bad_tag();
        test_flush();
`ifdef FPNEW_REQ_SCHED_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpnew_req_scheduler.md
FPNEW_REQ_SCHEDULER -- requirements
Module: fpnew_req_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters sharing one FPU instance (2..8).
REQ-002 SHALL have parameter MaxOutstanding, default 4, per-requester in-flight operation limit (1..15).
REQ-003 SHALL have parameter Width, default 64, FPU operand/result width; IdWidth = max(1, clog2(NumReq)) derived.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i / req_ready_o  in/out  NumReq  per-requester issue handshake.
REQ-007 req_i  in  NumReq x req_payload_t  per-requester operation (operands, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial_op).
REQ-008 fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU issue handshake; fpu_req_o out req_payload_t; fpu_tag_o out IdWidth.
REQ-009 fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU result handshake; fpu_rsp_i in rsp_payload_t (result, status); fpu_tag_i in IdWidth.
REQ-010 fpu_flush_o out 1, fpu_busy_i in 1: FPU flush and busy.
REQ-011 rsp_valid_o / rsp_ready_i  out/in  NumReq  per-requester result handshake; rsp_o out rsp_payload_t broadcast to all.
REQ-012 flush_i in 1 flush request; busy_o out 1; err_o out 1 sticky bad-tag flag.

Function
REQ-013 States: ARB, HOLD, DRAIN; reset state ARB.
REQ-014 ARB: eligible[k] = req_valid_i[k] & (cnt[k] < MaxOutstanding); grant lowest-index eligible at or after rr_ptr (wrap at NumReq).
REQ-015 fpu_in_valid_o = any eligible; fpu_req_o/fpu_tag_o = granted payload/index; req_ready_o[k] = grant[k] & fpu_in_ready_i; zero-cycle issue latency.
REQ-016 Granted but not accepted -> HOLD; HOLD keeps the same grant regardless of other requests until accepted, then -> ARB.
REQ-017 On issue handshake for k: rr_ptr <= (k+1) mod NumReq; cnt[k] += 1.
REQ-018 Response: rsp_valid_o[fpu_tag_i] = fpu_out_valid_i, others 0; fpu_out_ready_o = rsp_ready_i[fpu_tag_i]; rsp_o = fpu_rsp_i; zero latency.
REQ-019 On response handshake for k: cnt[k] -= 1; issue and response for same k in one cycle leaves cnt[k] unchanged.
REQ-020 fpu_tag_i >= NumReq with fpu_out_valid_i: fpu_out_ready_o = 1, no rsp_valid_o, err_o set until reset.
REQ-021 Response with cnt[k] == 0: delivered, counter saturates at 0, err_o set.
REQ-022 flush_i (any state): fpu_flush_o high that cycle, all cnt cleared, -> DRAIN; issue grant aborted.
REQ-023 DRAIN: fpu_in_valid_o = 0, req_ready_o = 0, rsp_valid_o = 0, fpu_out_ready_o = 1; -> ARB first cycle fpu_busy_i = 0 and flush_i = 0; rr_ptr preserved.
REQ-024 busy_o = (state != ARB) | any cnt != 0.

Reset
REQ-025 rst_i high: state ARB, rr_ptr 0, all cnt 0, err_o 0, fpu_flush_o 0; all valid/ready outputs 0 that cycle.
REQ-026 rst_i mid-operation discards in-flight bookkeeping; FPU reset by its own owner.

Configuration
REQ-027 FPNEW_REQ_SCHED_PERF_EN defined: per-requester 32-bit counters issued_o[k] (issue handshakes) and stall_o[k] (req_valid_i & !req_ready_o cycles), wrapping, cleared by reset only.
REQ-028 Undefined: issued_o/stall_o ports and counters absent; all other behaviour identical.

Structure
REQ-029 req_payload_t, rsp_payload_t, state enum in package fpnew_sched_pkg, parameterised by Width via fpnew_pkg types.
REQ-030 Sub-module fpnew_sched_rr_pick: combinational rotate-priority picker (eligible, rr_ptr -> grant one-hot, index).

Verification
REQ-031 NumReq=4, all valid, fpu_in_ready_i=1, responses immediate -> grants 0,1,2,3,0 on consecutive cycles.
REQ-032 Req 2 valid, fpu_in_ready_i=0 three cycles, req 0 raised cycle 2 -> fpu_tag_o stays 2 (HOLD) until accepted, then req 0.
REQ-033 MaxOutstanding=2, req 1 issues twice, no responses -> req_ready_o[1]=0; one response tag 1 -> third issue next cycle.
REQ-034 Issue and response tag 3 same cycle with cnt[3]=1 -> cnt[3] stays 1; fpu_tag_i=5 response -> dropped, err_o=1.
REQ-035 flush_i with 3 in flight, fpu_busy_i high 4 cycles -> fpu_flush_o one cycle, DRAIN 4 cycles, results swallowed, cnt all 0, busy_o low after exit.
REQ-036 With FPNEW_REQ_SCHED_PERF_EN, req 0 stalled 5 cycles then issued -> stall_o[0]=5, issued_o[0]=1.
